// File: rtl/img_mem_responder_pkg.sv
// Shared types and sizes for the CNN feature-memory responder.
//   DATA_SIZE : default word width in bits
//   N         : default maximum image side (buffer holds N*N words)
//   mem_state_t : responder FSM states
//   word_t      : signed feature word
package cnn_pkg;

  localparam int DATA_SIZE = 16;
  localparam int N         = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    DRAIN,
    WR,
    DONE
  } mem_state_t;

  typedef logic signed [DATA_SIZE-1:0] word_t;

endpackage

// File: rtl/img_mem_responder_mem_lat_pipe.sv
// Read-latency tag pipe: delays {valid, buffer index} of each issued RAM read
// by MEM_LAT cycles so the returning mem_rdata word arrives together with the
// image buffer slot it belongs to.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (clears valids only)
//   inValid, inIdx    : read strobe and buffer index as presented to the RAM
//   outValid, outIdx  : same tag, MEM_LAT cycles later, aligned with mem_rdata
module mem_lat_pipe #(
  parameter int MEM_LAT = 1,
  parameter int IDX_W   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  input  logic [IDX_W-1:0] inIdx,
  output logic             outValid,
  output logic [IDX_W-1:0] outIdx
);

  logic [MEM_LAT-1:0] vldPipe;
  logic [IDX_W-1:0]   idxPipe [MEM_LAT];

  // Valid bits are control: reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      vldPipe <= '0;
    end else begin
      vldPipe[0] <= inValid;
      for (int i = 1; i < MEM_LAT; i++) begin
        vldPipe[i] <= vldPipe[i-1];
      end
    end
  end

  // Index bits are data and only meaningful alongside a set valid.
  always_ff @(posedge clk) begin
    idxPipe[0] <= inIdx;
    for (int i = 1; i < MEM_LAT; i++) begin
      idxPipe[i] <= idxPipe[i-1];
    end
  end

  assign outValid = vldPipe[MEM_LAT-1];
  assign outIdx   = idxPipe[MEM_LAT-1];

endmodule

// File: rtl/img_mem_responder.sv
// Memory-side responder for CNN layer image load/store requests.
// A read copies min(size,N)^2 words from RAM starting at addr into the packed
// image buffer; a write stores the same number of words from wr_image to RAM.
// Completion is signalled with a single-cycle op_done pulse.
// Optional build macro:
//   CLEAR_TAIL_EN : on every accepted read, image words cnt..N*N-1 are zeroed
//                   at the accept edge so stale data never leaks downstream.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   req_en          : request level, held by the initiator until op_done
//   req_rw          : 1 = read, 0 = write (sampled at accept)
//   req_addr        : base word address (sampled at accept)
//   req_size        : image side (sampled at accept, clamped to N)
//   wr_image        : packed source image, word i at [i*DATA_SIZE +: DATA_SIZE]
//   image           : packed read buffer, same layout
//   op_done         : one-cycle completion pulse
//   busy            : high from accept through the op_done cycle
//   mem_addr        : RAM word address
//   mem_rd_en       : RAM read strobe
//   mem_rdata       : RAM data, valid MEM_LAT cycles after the read is sampled
//   mem_wr_en       : RAM write strobe
//   mem_wdata       : RAM write data
module img_mem_responder
  import cnn_pkg::*;
#(
  parameter int DATA_SIZE = cnn_pkg::DATA_SIZE,
  parameter int N         = cnn_pkg::N,
  parameter int MEM_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_en,
  input  logic                          req_rw,
  input  logic [DATA_SIZE-1:0]          req_addr,
  input  logic [DATA_SIZE-1:0]          req_size,
  input  logic [N*N*DATA_SIZE-1:0]      wr_image,
  output logic [N*N*DATA_SIZE-1:0]      image,
  output logic                          op_done,
  output logic                          busy,
  output logic [DATA_SIZE-1:0]          mem_addr,
  output logic                          mem_rd_en,
  input  logic [DATA_SIZE-1:0]          mem_rdata,
  output logic                          mem_wr_en,
  output logic [DATA_SIZE-1:0]          mem_wdata
);

  localparam int CW    = 2 * DATA_SIZE;
  localparam int WORDS = N * N;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  mem_state_t state, stateNext;

  logic [CW-1:0]        k, kNext;
  logic [CW-1:0]        cnt, cntNext;
  logic [DATA_SIZE-1:0] base, baseNext;
  logic [DATA_SIZE-1:0] addrNext, wdataNext;
  logic [IDX_W-1:0]     rdIdx, rdIdxNext;
  logic                 armed, armedNext;
  logic                 busyNext, opDoneNext, rdEnNext, wrEnNext;
  logic                 accept;
  logic                 capValid;
  logic [IDX_W-1:0]     capIdx;
  logic [IDX_W-1:0]     lastIdx;

  // Side is saturated to N before squaring; the product fits in CW bits.
  function automatic logic [CW-1:0] sqClamp(input logic [DATA_SIZE-1:0] side);
    logic [CW-1:0] s;
    s = (CW'(side) > CW'(N)) ? CW'(N) : CW'(side);
    return s * s;
  endfunction

  function automatic logic [DATA_SIZE-1:0] wrWord(input logic [IDX_W-1:0] idx);
    return wr_image[int'(idx)*DATA_SIZE +: DATA_SIZE];
  endfunction

  assign lastIdx = IDX_W'(cnt - CW'(1));

  mem_lat_pipe #(
    .MEM_LAT (MEM_LAT),
    .IDX_W   (IDX_W)
  ) u_latPipe (
    .clk      (clk),
    .reset    (reset),
    .inValid  (mem_rd_en),
    .inIdx    (rdIdx),
    .outValid (capValid),
    .outIdx   (capIdx)
  );

  always_comb begin
    stateNext  = state;
    kNext      = k;
    cntNext    = cnt;
    baseNext   = base;
    rdIdxNext  = rdIdx;
    addrNext   = mem_addr;
    wdataNext  = mem_wdata;
    rdEnNext   = 1'b0;
    wrEnNext   = 1'b0;
    // A low req_en re-arms; a held req_en can never retrigger.
    armedNext  = armed | ~req_en;
    // busy spans the op_done cycle and falls on the edge that ends it.
    busyNext   = busy & ~op_done;
    opDoneNext = (state == DONE);
    accept     = 1'b0;

    unique case (state)
      IDLE: begin
        // !busy keeps the op_done cycle from accepting a new request.
        if (req_en && armed && !busy) begin
          accept    = 1'b1;
          armedNext = 1'b0;
          busyNext  = 1'b1;
          baseNext  = req_addr;
          cntNext   = sqClamp(req_size);
          // Word 0 goes out on the accept edge itself; k counts issued words.
          kNext     = CW'(1);
          if (cntNext == '0) begin
            stateNext = DONE;
          end else if (req_rw) begin
            stateNext = RD;
            rdEnNext  = 1'b1;
            addrNext  = req_addr;
            rdIdxNext = '0;
          end else begin
            stateNext = WR;
            wrEnNext  = 1'b1;
            addrNext  = req_addr;
            wdataNext = wrWord('0);
          end
        end
      end
      RD: begin
        if (k < cnt) begin
          rdEnNext  = 1'b1;
          addrNext  = base + k[DATA_SIZE-1:0];
          rdIdxNext = k[IDX_W-1:0];
          kNext     = k + CW'(1);
        end else begin
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        // Reads return in issue order, so the last index closes the transfer.
        if (capValid && (capIdx == lastIdx)) begin
          stateNext = DONE;
        end
      end
      WR: begin
        if (k < cnt) begin
          wrEnNext  = 1'b1;
          addrNext  = base + k[DATA_SIZE-1:0];
          wdataNext = wrWord(k[IDX_W-1:0]);
          kNext     = k + CW'(1);
        end else begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_done   <= 1'b0;
      busy      <= 1'b0;
      armed     <= 1'b1;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= stateNext;
      op_done   <= opDoneNext;
      busy      <= busyNext;
      armed     <= armedNext;
      mem_rd_en <= rdEnNext;
      mem_wr_en <= wrEnNext;
      mem_addr  <= addrNext;
      mem_wdata <= wdataNext;
      k         <= kNext;
      cnt       <= cntNext;
      base      <= baseNext;
      rdIdx     <= rdIdxNext;
    end
  end

  // Image buffer is never reset; a reset edge also discards returning reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
`ifdef CLEAR_TAIL_EN
      if (accept && req_rw) begin
        for (int i = 0; i < WORDS; i++) begin
          if (CW'(i) >= cntNext) begin
            image[i*DATA_SIZE +: DATA_SIZE] <= '0;
          end
        end
      end
`endif
      if (capValid) begin
        image[int'(capIdx)*DATA_SIZE +: DATA_SIZE] <= mem_rdata;
      end
    end
  end

endmodule
